// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, alignment rule.
// No logic of its own; purely declarations and a combinational helper.
// Not applicable: no handshake lives here.
package lsu_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

   typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, FAULT, RESP} state_e;

   // Natural alignment: the byte offset must be a multiple of the access size.
   function automatic logic is_misaligned(input size_e size, input logic [2:0] offset);
      logic mis;
      case (size)
         SZ_H:    mis = offset[0];
         SZ_W:    mis = |offset[1:0];
         SZ_D:    mis = |offset;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-doubleword store merge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] rd,
   input  logic [DATA_W-1:0] wdata,
   input  size_e             size,
   input  logic [2:0]        offset,
   input  logic              zext,
   output logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] st_data
);

   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] bmask;
   logic [5:0]        sh;

   always_comb begin
      sh      = {offset, 3'b000};
      lane    = rd >> sh;
      ld_data = lane;
      bmask   = '1;
      case (size)
         SZ_B: begin
            bmask   = {{(DATA_W-8){1'b0}}, 8'hFF};
            ld_data = {{(DATA_W-8){~zext & lane[7]}}, lane[7:0]};
         end
         SZ_H: begin
            bmask   = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            ld_data = {{(DATA_W-16){~zext & lane[15]}}, lane[15:0]};
         end
         SZ_W: begin
            bmask   = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
            ld_data = {{(DATA_W-32){~zext & lane[31]}}, lane[31:0]};
         end
         default: begin
            bmask   = '1;
            ld_data = lane;
         end
      endcase
      // Bytes outside the addressed lanes keep the value read from memory.
      st_data = (rd & ~(bmask << sh)) | ((wdata & bmask) << sh);
   end

endmodule

// File: rtl/lsu_dmem_master.sv
// RV64 load/store master for a word-organised memory without byte enables.
// Latency: load/store-double/fault resp 2 cycles after accept, sub-word store 3.
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse, never stalled.
module lsu_dmem_master
   import lsu_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [63:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_misaligned,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   input  logic [DATA_W-1:0]     rd
);

   if (DATA_W != 64) begin : g_bad_width
      $error("lsu_dmem_master: DATA_W must be 64");
   end

   state_e            state, state_n;
   size_e             size_q;
   logic              zext_q;
   logic [2:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] ld_data, st_data;
   logic              accept;
   logic              unused_addr_bits;

   // Address bits above the memory size are dropped, so accesses wrap.
   assign unused_addr_bits = ^req_addr[63:DM_ADDRESS+3];

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (is_misaligned(size_e'(req_size), req_addr[2:0])) state_n = FAULT;
               else if (!req_we)                                    state_n = LD;
               else if (size_e'(req_size) == SZ_D)                  state_n = ST_WR;
               else                                                 state_n = ST_RD;
            end
         end
         LD:      state_n = RESP;
         ST_RD:   state_n = ST_WR;
         ST_WR:   state_n = RESP;
         FAULT:   state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they are glitch-free registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         size_q          <= SZ_B;
         zext_q          <= 1'b0;
         off_q           <= '0;
         wdata_q         <= '0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         MemRead         <= 1'b0;
         MemWrite        <= 1'b0;
         a               <= '0;
         wd              <= '0;
      end else begin
         state           <= state_n;
         MemRead         <= (state_n == LD) || (state_n == ST_RD);
         MemWrite        <= (state_n == ST_WR);
         resp_valid      <= (state_n == RESP);
         resp_misaligned <= (state == FAULT);
         if (accept) begin
            size_q     <= size_e'(req_size);
            zext_q     <= req_unsigned;
            off_q      <= req_addr[2:0];
            wdata_q    <= req_wdata;
            a          <= req_addr[DM_ADDRESS+2:3];
            resp_rdata <= '0;
            if (state_n == ST_WR) wd <= req_wdata;
         end
         if (state == LD)    resp_rdata <= ld_data;
         if (state == ST_RD) wd         <= st_data;
      end
   end

   lsu_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .rd      (rd),
      .wdata   (wdata_q),
      .size    (size_q),
      .offset  (off_q),
      .zext    (zext_q),
      .ld_data (ld_data),
      .st_data (st_data)
   );

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Vector table of loads/stores against a behavioural memory, plus a reset-abort sequence.
// Expected data/latency/strobe counts come from the table; responses checked via a queue.
module tb_lsu_dmem_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_misaligned;
   logic        MemRead, MemWrite;
   logic [8:0]  a;
   logic [63:0] wd, rd;

   logic [63:0] mem [512];

   always #5 clk = ~clk;

   lsu_dmem_master #(.DM_ADDRESS(9), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .MemRead(MemRead), .MemWrite(MemWrite),
      .a(a), .wd(wd), .rd(rd)
   );

   assign rd = mem[a];
   always @(posedge clk) if (MemWrite) mem[a] <= wd;

   int          checks = 0;
   int          errors = 0;
   int          n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0, n_long_resp = 0;
   logic [8:0]  last_ra, last_wa;
   logic [63:0] last_wd;
   logic        resp_prev = 1'b0;

   always @(negedge clk) begin
      if (MemRead)  begin n_rd++; last_ra = a; end
      if (MemWrite) begin n_wr++; last_wa = a; last_wd = wd; end
      if (MemRead && MemWrite) n_both++;
      if (resp_valid) n_resp++;
      if (resp_valid && resp_prev) n_long_resp++;
      resp_prev = resp_valid;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        zx;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_mis;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic [8:0]  exp_a;
      logic [63:0] exp_wd;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[20];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic zx,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic mis, input int lat,
                               input int nrd, input int nwr, input logic [8:0] ea,
                               input logic [63:0] ewd);
      vec_t v;
      v.we = we; v.size = size; v.zx = zx; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = rdata; v.exp_mis = mis; v.exp_lat = lat;
      v.exp_nrd = nrd; v.exp_nwr = nwr; v.exp_a = ea; v.exp_wd = ewd;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Drives one request from a negedge in IDLE and returns at the negedge after RESP.
   task automatic do_req(input string tag, input vec_t v);
      int   lat, rd0, wr0;
      exp_t e, got;
      e.rdata = v.exp_rdata;
      e.mis   = v.exp_mis;
      sb.push_back(e);
      rd0 = n_rd;
      wr0 = n_wr;
      check({tag, "_ready_idle"}, {63'b0, req_ready}, 64'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.zx;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size; req_unsigned = ~v.zx;
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      check({tag, "_ready_busy"}, {63'b0, req_ready}, 64'd0);
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, lat, v.exp_lat);
      got = sb.pop_front();
      if (resp_valid) begin
         check({tag, "_rdata"}, resp_rdata, got.rdata);
         check({tag, "_misaligned"}, {63'b0, resp_misaligned}, {63'b0, got.mis});
      end else begin
         check({tag, "_resp_seen"}, 64'd0, 64'd1);
      end
      check({tag, "_reads"}, n_rd - rd0, v.exp_nrd);
      check({tag, "_writes"}, n_wr - wr0, v.exp_nwr);
      if (v.exp_nrd > 0) check({tag, "_read_a"}, last_ra, v.exp_a);
      if (v.exp_nwr > 0) begin
         check({tag, "_write_a"}, last_wa, v.exp_a);
         check({tag, "_wd"}, last_wd, v.exp_wd);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int wr0, resp0;
      foreach (mem[i]) mem[i] = 64'd0;
      mem[5] = 64'hF0E0D0C0B0A09080;
      mem[6] = 64'h5A5A5A5A5A5A5A5A;

      //         we size zx addr        wdata                 rdata                 mis lat rd wr a  wd
      vecs[0]  = mk(0, 0, 0, 64'h2F, 64'h0, 64'hFFFFFFFFFFFFFFF0, 0, 2, 1, 0, 5, 0);
      vecs[1]  = mk(0, 0, 1, 64'h2F, 64'h0, 64'h00000000000000F0, 0, 2, 1, 0, 5, 0);
      vecs[2]  = mk(0, 1, 0, 64'h2C, 64'h0, 64'hFFFFFFFFFFFFD0C0, 0, 2, 1, 0, 5, 0);
      vecs[3]  = mk(0, 1, 1, 64'h2C, 64'h0, 64'h000000000000D0C0, 0, 2, 1, 0, 5, 0);
      vecs[4]  = mk(0, 2, 0, 64'h28, 64'h0, 64'hFFFFFFFFB0A09080, 0, 2, 1, 0, 5, 0);
      vecs[5]  = mk(0, 2, 1, 64'h2C, 64'h0, 64'h00000000F0E0D0C0, 0, 2, 1, 0, 5, 0);
      vecs[6]  = mk(0, 3, 0, 64'h28, 64'h0, 64'hF0E0D0C0B0A09080, 0, 2, 1, 0, 5, 0);
      vecs[7]  = mk(1, 0, 0, 64'h29, 64'hAAAAAAAAAAAAAA11, 64'h0, 0, 3, 1, 1, 5, 64'hF0E0D0C0B0A01180);
      vecs[8]  = mk(0, 3, 0, 64'h28, 64'h0, 64'hF0E0D0C0B0A01180, 0, 2, 1, 0, 5, 0);
      vecs[9]  = mk(1, 3, 0, 64'h30, 64'h0123456789ABCDEF, 64'h0, 0, 2, 0, 1, 6, 64'h0123456789ABCDEF);
      vecs[10] = mk(0, 3, 0, 64'h30, 64'h0, 64'h0123456789ABCDEF, 0, 2, 1, 0, 6, 0);
      vecs[11] = mk(0, 2, 0, 64'h2A, 64'h0, 64'h0, 1, 2, 0, 0, 0, 0);
      vecs[12] = mk(1, 1, 0, 64'h36, 64'h000055550000BEEF, 64'h0, 0, 3, 1, 1, 6, 64'hBEEF456789ABCDEF);
      vecs[13] = mk(0, 0, 0, 64'h37, 64'h0, 64'hFFFFFFFFFFFFFFBE, 0, 2, 1, 0, 6, 0);
      vecs[14] = mk(1, 2, 0, 64'h34, 64'hFFFFFFFF12345678, 64'h0, 0, 3, 1, 1, 6, 64'h1234567889ABCDEF);
      vecs[15] = mk(0, 3, 1, 64'h30, 64'h0, 64'h1234567889ABCDEF, 0, 2, 1, 0, 6, 0);
      vecs[16] = mk(1, 1, 0, 64'h31, 64'hFFFF, 64'h0, 1, 2, 0, 0, 0, 0);
      vecs[17] = mk(0, 3, 0, 64'h1028, 64'h0, 64'hF0E0D0C0B0A01180, 0, 2, 1, 0, 5, 0);
      vecs[18] = mk(0, 1, 0, 64'h32, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, 2, 1, 0, 6, 0);
      vecs[19] = mk(0, 0, 1, 64'h33, 64'h0, 64'h0000000000000089, 0, 2, 1, 0, 6, 0);

      repeat (3) @(negedge clk);
      check("rst_ready", {63'b0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_resp_mis", {63'b0, resp_misaligned}, 64'd0);
      check("rst_strobes", {62'b0, MemRead, MemWrite}, 64'd0);
      check("rst_a", {55'b0, a}, 64'd0);
      check("rst_wd", wd, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) do_req($sformatf("v%0d", i), vecs[i]);

      // Reset pulsed while a half-word store is in its read phase.
      wr0 = n_wr;
      resp0 = n_resp;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 64'h28; req_wdata = 64'h7777;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_in_st_rd", {62'b0, MemRead, MemWrite}, 64'd2);
      rst_n = 1'b0;
      #1;
      check("abort_strobes", {62'b0, MemRead, MemWrite}, 64'd0);
      check("abort_a", {55'b0, a}, 64'd0);
      check("abort_wd", wd, 64'd0);
      check("abort_resp", {62'b0, resp_valid, resp_misaligned}, 64'd0);
      check("abort_rdata", resp_rdata, 64'd0);
      check("abort_ready", {63'b0, req_ready}, 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_write", n_wr - wr0, 0);
      check("abort_no_resp", n_resp - resp0, 0);
      check("abort_mem5", mem[5], 64'hF0E0D0C0B0A01180);
      check("abort_ready_after", {63'b0, req_ready}, 64'd1);
      do_req("post_abort_ld",
             mk(0, 3, 0, 64'h28, 64'h0, 64'hF0E0D0C0B0A01180, 0, 2, 1, 0, 5, 0));

      check("strobe_overlap", n_both, 0);
      check("resp_pulse_width", n_long_resp, 0);
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit that sits between the execute stage and the 64-bit word-organised data memory.
- Accepts one RV64 load or store per handshake and drives the memory's MemRead/MemWrite/a/wd strobes from registers.
- On loads, extracts the addressed byte, half, word or doubleword and sign- or zero-extends it.
- The memory has no byte enables, so sub-doubleword stores are done as read-modify-write.

Parameters:
- DM_ADDRESS, 9: memory word-index width; 2**DM_ADDRESS 64-bit words.
- DATA_W, 64: data width. Only 64 is legal; elaboration assertion otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double (funct3[1:0]).
- req_unsigned  in  1  zero-extend the load (funct3[2]); ignored for stores and for size 3.
- req_addr  in  64  byte address from the ALU.
- req_wdata  in  DATA_W  store data; the value sits in the low-order bytes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- resp_misaligned  out  1  qualifies resp_valid; the access was misaligned and not performed.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- a  out  DM_ADDRESS  memory word index.
- wd  out  DATA_W  memory write data.
- rd  in  DATA_W  memory read data; combinational from a.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_misaligned=0.
  - MemRead=0, MemWrite=0, a=0, wd=0.
- Address split:
  - word index = req_addr[DM_ADDRESS+2:3].
  - offset = req_addr[2:0].
  - Higher address bits are ignored, so accesses wrap modulo memory size.
- Misalignment: size1 needs addr[0]=0; size2 needs addr[1:0]=0; size3 needs addr[2:0]=0.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready. All request fields are captured at acceptance; later input changes have no effect.
- States and transitions:
  - IDLE: on accept, misaligned -> FAULT; load -> LD; store size3 -> ST_WR; store size 0-2 -> ST_RD.
  - LD: MemRead=1, a=index. At the closing edge, capture rd into resp_rdata. -> RESP.
  - ST_RD: MemRead=1. At the closing edge, capture rd and merge the new bytes into wd. -> ST_WR.
  - ST_WR: MemWrite=1; a and wd are stable for the whole cycle. -> RESP.
  - FAULT: no strobes. -> RESP with resp_misaligned=1.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE.
- Latency from the accept edge to resp_valid high:
  - load 2 cycles.
  - store-double 2 cycles.
  - sub-word store 3 cycles.
  - fault 2 cycles.
- Throughput is one request per (latency+1) cycles. The response has no backpressure.
- Strobe invariants:
  - MemRead and MemWrite are never both 1.
  - MemWrite is high for exactly one cycle per store.
  - All memory outputs are registers, so there are no glitches.
- Load extract:
  - lane = rd >> (8*offset), truncated to 8/16/32/64 bits.
  - Sign-extend from the top lane bit unless req_unsigned=1; size3 is never extended.
- Store merge: wd = (rd & ~mask) | ((req_wdata & lanemask) << 8*offset), where mask covers 1/2/4 bytes at offset.
- Reset mid-operation: the operation is abandoned immediately.
  - Strobes drop asynchronously and no response is produced.
  - A store in ST_RD leaves memory unchanged.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum size_e {SZ_B, SZ_H, SZ_W, SZ_D}.
  - typedef enum state_e {IDLE, LD, ST_RD, ST_WR, FAULT, RESP}.
  - function is_misaligned(size, offset).
- Sub-module lsu_lane_align (combinational) provides:
  - load extract/extend: rd, size, offset, unsigned -> data.
  - store merge: rd, wdata, size, offset -> wd.
- The top level holds only the FSM and registers.

Test Plan:
- Word 5 = 0xF0E0D0C0B0A09080; LB at addr 0x2F -> MemRead pulse with a=5; 2 cycles after accept resp_rdata=0xFFFFFFFFFFFFFFF0; LBU at the same address -> 0x00000000000000F0.
- LH at 0x2C -> 0xFFFFFFFFFFFFD0C0; LW at 0x28 -> 0xFFFFFFFFB0A09080; LD at 0x28 -> 0xF0E0D0C0B0A09080.
- SB wdata=0x11 at 0x29 -> one MemRead then one MemWrite with wd=0xF0E0D0C0B0A01180; resp_valid 3 cycles after accept; a subsequent LD returns that value.
- SD 0x0123456789ABCDEF at 0x30 -> no MemRead; single MemWrite with a=6; resp_valid 2 cycles after accept.
- LW at 0x2A -> resp_valid with resp_misaligned=1, resp_rdata=0; MemRead and MemWrite stay 0 throughout.
- SH at 0x28 with rst_n pulsed low during ST_RD -> MemWrite never asserts; word 5 unchanged; all outputs at reset values; req_ready=1 after release.
